// File: rtl/handshake_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | handshake_pkg                                                        |
// | Slice mode encodings and occupancy helper shared by the slice chain. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package handshake_pkg;

    localparam int MODE_FWD  = 0;
    localparam int MODE_BWD  = 1;
    localparam int MODE_FULL = 2;

    // Largest number of words a chain of the given mode and depth can hold.
    function automatic int max_occupancy(input int mode, input int stages);
        return (mode == MODE_FULL) ? 2 * stages : stages;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_slice_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_slice_stage                                                      |
// | One valid/ready register slice: forward, backward or full (skid).    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module reg_slice_stage
    import handshake_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int MODE  = MODE_FULL
) (
    input  logic             clk,
    input  logic             s_rst,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i,
    output logic [1:0]       held_o
);

    if (MODE == MODE_FWD) begin : g_fwd
        logic             valid_q;
        logic [WIDTH-1:0] data_q;

        always_ff @(posedge clk) begin
            if (s_rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (in_valid_i && in_ready_o) begin
                valid_q <= 1'b1;
                data_q  <= in_data_i;
            end else if (out_ready_i) begin
                valid_q <= 1'b0;
            end
        end

        assign in_ready_o  = !valid_q || out_ready_i;
        assign out_valid_o = valid_q;
        assign out_data_o  = data_q;
        assign held_o      = {1'b0, valid_q};

    end else if (MODE == MODE_BWD) begin : g_bwd
        logic             skid_full_q;
        logic [WIDTH-1:0] skid_q;

        // Ready is the inverted skid flag, so it comes straight from a flop.
        always_ff @(posedge clk) begin
            if (s_rst) begin
                skid_full_q <= 1'b0;
                skid_q      <= '0;
            end else if (skid_full_q) begin
                if (out_ready_i) begin
                    skid_full_q <= 1'b0;
                end
            end else if (in_valid_i && !out_ready_i) begin
                skid_full_q <= 1'b1;
                skid_q      <= in_data_i;
            end
        end

        assign in_ready_o  = !skid_full_q;
        assign out_valid_o = skid_full_q || in_valid_i;
        assign out_data_o  = skid_full_q ? skid_q : in_data_i;
        assign held_o      = {1'b0, skid_full_q};

    end else begin : g_full
        logic             main_valid_q;
        logic             main_valid_d;
        logic [WIDTH-1:0] main_q;
        logic [WIDTH-1:0] main_d;
        logic             skid_full_q;
        logic             skid_full_d;
        logic [WIDTH-1:0] skid_q;
        logic [WIDTH-1:0] skid_d;
        logic             w_push;
        logic             w_pop;

        assign w_push = in_valid_i && !skid_full_q;
        assign w_pop  = main_valid_q && out_ready_i;

        always_comb begin
            main_valid_d = main_valid_q;
            main_d       = main_q;
            skid_full_d  = skid_full_q;
            skid_d       = skid_q;
            if (w_pop) begin
                // A full skid refills main; ready only returns next cycle.
                if (skid_full_q) begin
                    main_d      = skid_q;
                    skid_full_d = 1'b0;
                end else if (w_push) begin
                    main_d = in_data_i;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (w_push) begin
                if (main_valid_q) begin
                    skid_d      = in_data_i;
                    skid_full_d = 1'b1;
                end else begin
                    main_d       = in_data_i;
                    main_valid_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (s_rst) begin
                main_valid_q <= 1'b0;
                main_q       <= '0;
                skid_full_q  <= 1'b0;
                skid_q       <= '0;
            end else begin
                main_valid_q <= main_valid_d;
                main_q       <= main_d;
                skid_full_q  <= skid_full_d;
                skid_q       <= skid_d;
            end
        end

        assign in_ready_o  = !skid_full_q;
        assign out_valid_o = main_valid_q;
        assign out_data_o  = main_q;
        assign held_o      = {1'b0, main_valid_q} + {1'b0, skid_full_q};
    end

endmodule
`default_nettype wire

// File: rtl/reg_slice_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_slice_pipe                                                       |
// | Chain of STAGES valid/ready slices with live occupancy reporting.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module reg_slice_pipe
    import handshake_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int STAGES = 1,
    parameter int MODE   = MODE_FULL
) (
    input  logic                             clk,
    input  logic                             s_rst,
    input  logic                             src_vaild,
    input  logic [WIDTH-1:0]                 src_data_in,
    output logic                             src_ready,
    output logic                             dst_vaild,
    output logic [WIDTH-1:0]                 dst_data_out,
    input  logic                             dst_ready,
    output logic [$clog2(2*STAGES+1)-1:0]    occupancy
);

    localparam int OCC_W   = $clog2(2 * STAGES + 1);
    localparam int OCC_MAX = max_occupancy(MODE, STAGES);

    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $error("reg_slice_pipe: STAGES=%0d outside 1..8", STAGES);
    end
    if (MODE != MODE_FWD && MODE != MODE_BWD && MODE != MODE_FULL) begin : g_bad_mode
        $error("reg_slice_pipe: MODE=%0d is not a slice type", MODE);
    end
    if (OCC_MAX >= (1 << OCC_W)) begin : g_bad_occ
        $error("reg_slice_pipe: occupancy port too narrow for %0d words", OCC_MAX);
    end

    logic             w_valid [STAGES+1];
    logic [WIDTH-1:0] w_data  [STAGES+1];
    logic             w_ready [STAGES+1];
    logic [1:0]       w_held  [STAGES];

    // Gating the entry keeps pass-through slices quiet while in reset.
    assign w_valid[0]       = src_vaild && !s_rst;
    assign w_data[0]        = s_rst ? '0 : src_data_in;
    assign src_ready        = w_ready[0] && !s_rst;
    assign dst_vaild        = w_valid[STAGES];
    assign dst_data_out     = w_data[STAGES];
    assign w_ready[STAGES]  = dst_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        reg_slice_stage #(
            .WIDTH (WIDTH),
            .MODE  (MODE)
        ) u_stage (
            .clk         (clk),
            .s_rst       (s_rst),
            .in_valid_i  (w_valid[i]),
            .in_data_i   (w_data[i]),
            .in_ready_o  (w_ready[i]),
            .out_valid_o (w_valid[i+1]),
            .out_data_o  (w_data[i+1]),
            .out_ready_i (w_ready[i+1]),
            .held_o      (w_held[i])
        );
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OCC_W'(w_held[i]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_slice_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reg_slice_pipe                                                    |
// | Scoreboard bench over six slice-chain configurations.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_reg_slice_pipe;

    localparam int NDUT = 6;

    // 0:FULL/2  1:FULL/1  2:BWD/1  3:FWD/3  4:BWD/3  5:FULL/3
    function automatic int cfg_mode(input int i);
        case (i)
            2, 4:    return 1;
            3:       return 0;
            default: return 2;
        endcase
    endfunction

    function automatic int cfg_stages(input int i);
        case (i)
            0:       return 2;
            1, 2:    return 1;
            default: return 3;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       s_rst;
    logic       sv  [NDUT];
    logic [8:0] sd  [NDUT];
    logic       dr  [NDUT];
    logic       sr  [NDUT];
    logic       dv  [NDUT];
    logic [8:0] dd  [NDUT];
    logic [3:0] occ [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int ST = cfg_stages(g);
        localparam int OW = $clog2(2 * ST + 1);
        logic [OW-1:0] occ_w;

        reg_slice_pipe #(
            .WIDTH  (9),
            .STAGES (ST),
            .MODE   (cfg_mode(g))
        ) u_dut (
            .clk          (clk),
            .s_rst        (s_rst),
            .src_vaild    (sv[g]),
            .src_data_in  (sd[g]),
            .src_ready    (sr[g]),
            .dst_vaild    (dv[g]),
            .dst_data_out (dd[g]),
            .dst_ready    (dr[g]),
            .occupancy    (occ_w)
        );

        assign occ[g] = 4'(occ_w);
    end

    int         checks = 0;
    int         errors = 0;
    int         sel    = 0;
    int         n_in;
    int         n_out;
    logic [8:0] sb [$];
    logic       o_sr, o_dv;
    logic [8:0] o_dd;
    logic [3:0] o_occ;
    logic       acc, pop;
    logic       prev_stall;
    logic [8:0] prev_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of the selected DUT: drive, sample, score.
    task automatic step(input logic v, input logic [8:0] d, input logic r);
        @(negedge clk);
        sv[sel] = v;
        sd[sel] = d;
        dr[sel] = r;
        #1;
        o_sr  = sr[sel];
        o_dv  = dv[sel];
        o_dd  = dd[sel];
        o_occ = occ[sel];
        if (prev_stall) begin
            chk("hold_valid", 32'(o_dv), 32'd1);
            chk("hold_data", 32'(o_dd), 32'(prev_data));
        end
        acc = v && o_sr;
        pop = o_dv && r;
        if (acc) begin
            sb.push_back(d);
            n_in++;
        end
        if (pop) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 32'(o_dv), 32'd0);
            end else begin
                chk("sb_data", 32'(o_dd), 32'(sb.pop_front()));
                n_out++;
            end
        end
        prev_stall = o_dv && !r;
        prev_data  = o_dd;
    endtask

    task automatic select(input int idx);
        sel        = idx;
        prev_stall = 1'b0;
        n_in       = 0;
        n_out      = 0;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic       v, r;
        logic [8:0] nxt;
        logic       pend;
        int         cnt;

        s_rst = 1'b1;
        for (int j = 0; j < NDUT; j++) begin
            sv[j] = 1'b1;
            sd[j] = 9'h1FF;
            dr[j] = 1'b1;
        end

        // Reset held for five cycles with valid offered on every DUT.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            for (int j = 0; j < NDUT; j++) begin
                chk("rst_src_ready", 32'(sr[j]), 32'd0);
                chk("rst_dst_valid", 32'(dv[j]), 32'd0);
                chk("rst_dst_data", 32'(dd[j]), 32'd0);
                chk("rst_occupancy", 32'(occ[j]), 32'd0);
            end
        end
        @(negedge clk);
        s_rst = 1'b0;
        for (int j = 0; j < NDUT; j++) begin
            sv[j] = 1'b0;
            dr[j] = 1'b0;
        end
        #1;
        for (int j = 0; j < NDUT; j++) begin
            chk("release_src_ready", 32'(sr[j]), 32'd1);
        end

        // FULL, 2 stages: back-to-back stream with latency 2.
        select(0);
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 9'(i), 1'b1);
            chk("stream_accept", 32'(acc), 32'd1);
            if (i < 2) chk("stream_latency", 32'(o_dv), 32'd0);
            else       chk("stream_rate", 32'(o_dv), 32'd1);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 9'd0, 1'b1);
        chk("stream_count", 32'(n_out), 32'd256);
        chk("stream_empty", 32'(sb.size()), 32'd0);

        // FULL, 1 stage: fill main and skid, then drain.
        select(1);
        step(1'b1, 9'h001, 1'b0);
        chk("full1_acc1", 32'(acc), 32'd1);
        step(1'b1, 9'h002, 1'b0);
        chk("full1_acc2", 32'(acc), 32'd1);
        step(1'b1, 9'h003, 1'b0);
        chk("full1_acc3_blocked", 32'(acc), 32'd0);
        chk("full1_occ2", 32'(o_occ), 32'd2);
        step(1'b1, 9'h003, 1'b1);
        chk("full1_pop_no_refill", 32'(o_sr), 32'd0);
        chk("full1_pop1", 32'(pop), 32'd1);
        step(1'b1, 9'h003, 1'b1);
        chk("full1_ready_back", 32'(acc), 32'd1);
        chk("full1_occ_after_pop", 32'(o_occ), 32'd1);
        step(1'b0, 9'h000, 1'b1);
        step(1'b0, 9'h000, 1'b1);
        chk("full1_dst_idle", 32'(o_dv), 32'd0);
        chk("full1_count", 32'(n_out), 32'd3);

        // BWD, 1 stage: pass-through, then skid capture.
        select(2);
        step(1'b1, 9'h155, 1'b1);
        chk("bwd_pass_valid", 32'(o_dv), 32'd1);
        chk("bwd_pass_data", 32'(o_dd), 32'h155);
        step(1'b1, 9'h0AA, 1'b0);
        chk("bwd_skid_accept", 32'(acc), 32'd1);
        step(1'b0, 9'h000, 1'b0);
        chk("bwd_skid_ready", 32'(o_sr), 32'd0);
        chk("bwd_skid_occ", 32'(o_occ), 32'd1);
        step(1'b0, 9'h000, 1'b1);
        chk("bwd_skid_pop", 32'(pop), 32'd1);
        step(1'b0, 9'h000, 1'b1);
        chk("bwd_ready_back", 32'(o_sr), 32'd1);
        chk("bwd_count", 32'(n_out), 32'd2);

        // Random traffic on each mode at three stages.
        for (int m = 3; m < 6; m++) begin
            select(m);
            nxt  = 9'd0;
            pend = 1'b0;
            v    = 1'b0;
            for (int c = 0; c < 300; c++) begin
                if (!pend) v = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 2) != 0);
                step(v, nxt, r);
                if (acc) nxt = nxt + 9'd1;
                pend = v && !acc;
            end
            for (int c = 0; c < 30; c++) step(1'b0, nxt, 1'b1);
            chk("rand_drained", 32'(sb.size()), 32'd0);
            chk("rand_in_out", 32'(n_out), 32'(n_in));
            chk("rand_occ_zero", 32'(o_occ), 32'd0);
        end

        // FULL, 2 stages: fill to 4 then reset mid-flight.
        select(0);
        nxt = 9'h1A0;
        cnt = 0;
        for (int c = 0; c < 10 && cnt < 4; c++) begin
            step(1'b1, nxt, 1'b0);
            if (acc) begin
                nxt = nxt + 9'd1;
                cnt++;
            end
        end
        chk("fill_count", 32'(cnt), 32'd4);
        step(1'b0, 9'h000, 1'b0);
        chk("fill_occ4", 32'(o_occ), 32'd4);
        chk("fill_ready_low", 32'(o_sr), 32'd0);
        @(negedge clk);
        s_rst      = 1'b1;
        prev_stall = 1'b0;
        #1;
        chk("midrst_ready_forced", 32'(sr[0]), 32'd0);
        @(negedge clk);
        s_rst = 1'b0;
        #1;
        chk("midrst_occ", 32'(occ[0]), 32'd0);
        chk("midrst_valid", 32'(dv[0]), 32'd0);
        chk("midrst_ready", 32'(sr[0]), 32'd1);
        sb.delete();
        for (int c = 0; c < 10; c++) step(1'b0, 9'h000, 1'b1);
        chk("midrst_no_output", 32'(n_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_slice_pipe.md
# reg_slice_pipe

Parametrised valid/ready register slice chain, the successor of the single forward-registered stage. It sits between any `source`-style producer and `destination`-style consumer in the handshake test chain, or between datapath blocks. It inserts `STAGES` register slices in one of three modes (forward, backward, full/skid) for timing closure. It reports live occupancy and never loses, duplicates or reorders words.

## Interface
- `WIDTH`, 9: data width in bits.
- `STAGES`, 1: number of chained slices; legal range 1..8.
- `MODE`, 2: slice type for every stage.
  - 0 = FWD (valid/data registered).
  - 1 = BWD (ready registered).
  - 2 = FULL (both registered, 2-entry skid).

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `s_rst`  in  1  reset; synchronous, active-high.
- `src_vaild`  in  1  upstream word valid.
- `src_data_in`  in  WIDTH  upstream data.
- `src_ready`  out  1  slice can accept this cycle.
- `dst_vaild`  out  1  downstream word valid.
- `dst_data_out`  out  WIDTH  downstream data.
- `dst_ready`  in  1  downstream accepts.
- `occupancy`  out  $clog2(2*STAGES+1)  words currently held in all stages.

## Operation
- Transfer happens on any edge where valid and ready are both 1, on either side.
- Upstream must hold `src_vaild` and `src_data_in` stable until accepted. The block guarantees the same on the output: once `dst_vaild`=1, `dst_vaild` and `dst_data_out` stay constant until `dst_ready`=1.
- FWD stage: one register plus a valid flag.
  - Ready toward upstream = !valid_q | ready from downstream (combinational).
  - Loads on upstream handshake.
  - Clears valid on downstream handshake with no new load.
- BWD stage: pass-through plus a one-entry skid register.
  - Ready toward upstream = !skid_full, registered.
  - While the skid is empty, out valid/data = in valid/data.
  - Input accepted while downstream not ready -> capture into skid.
  - While the skid is full, the skid drives the output and upstream ready=0.
- FULL stage: a main register and a skid register.
  - Ready toward upstream = !skid_full, registered.
  - Output always comes from main.
  - Accept while main is valid and downstream stalls -> word goes to skid.
  - Downstream handshake -> skid moves to main (or the new input if the skid is empty).
- `occupancy` = sum of held entries. Max is STAGES for FWD/BWD and 2*STAGES for FULL.
  - Updates in the cycle after the push/pop edge.
  - Simultaneous push and pop -> unchanged.
- Reset (any time, including mid-transfer):
  - All valid/skid flags are cleared and data regs are zeroed on the next edge.
  - Held words are discarded and are not delivered after reset.
  - While `s_rst`=1, `src_ready` is forced to 0 in all modes.

## Timing
- Reset values: `dst_vaild`=0, `dst_data_out`=0, `occupancy`=0.
- `src_ready`=0 during reset, =1 on the first cycle after `s_rst` falls.
- Latency from accept to `dst_vaild`:
  - FWD: STAGES cycles.
  - FULL: STAGES cycles.
  - BWD: 0 cycles (combinational) when all skids are empty.
- Throughput: 1 word/clock in every mode with `dst_ready` held at 1.
- Combinational paths:
  - FWD: ready path only.
  - BWD: valid/data path only.
  - FULL: none, all outputs come from flops.
- Full boundary (FULL, STAGES=1): after 2 accepts with `dst_ready`=0, `src_ready`=0 on the next cycle.
  - Simultaneous pop with skid full: `src_ready` returns to 1 one cycle later. There is no same-cycle refill.
- Empty boundary: a pop and a push on the same edge in FWD with valid_q=1 -> the register reloads and `dst_vaild` stays 1.

## Structure
- Shared package `handshake_pkg`:
  - Mode constants `MODE_FWD`=0, `MODE_BWD`=1, `MODE_FULL`=2.
  - A function returning max occupancy per mode.
- Sub-module `reg_slice_stage`:
  - Parameters `WIDTH`, `MODE`.
  - One slice with its own valid/ready/data ports and a 2-bit held-count output.
- Top level:
  - Generate chain of `STAGES` instances.
  - Adder tree for `occupancy`.
  - Reset gating of `src_ready`.
  - Parameter range check that stops simulation with an error when STAGES is outside 1..8.

## Test plan
- Reset: `s_rst`=1 for 5 cycles with `src_vaild`=1 -> `src_ready`=0, `dst_vaild`=0, `occupancy`=0 throughout; `src_ready`=1 on the first cycle after release.
- FULL, STAGES=2, `dst_ready`=1: push 0..255 back-to-back -> output 0..255 in order, first word 2 cycles after the first accept, one word per clock.
- FULL, STAGES=1, `dst_ready`=0: offer 0x001, 0x002, 0x003 -> exactly 2 accepted, `src_ready`=0, `occupancy`=2. Raise `dst_ready` -> 0x001, 0x002, 0x003 on consecutive handshakes.
- BWD, STAGES=1, skid empty: `src_data_in`=0x155 with `src_vaild`=1 -> `dst_vaild`=1 and `dst_data_out`=0x155 in the same cycle. Drop `dst_ready` -> word held in skid and `src_ready`=0 next cycle.
- Each MODE with STAGES=3, random `src_vaild`/`dst_ready` for 300 cycles, checked by a scoreboard -> no loss, duplication or reorder, and output stable under stall.
- FULL, STAGES=2, `occupancy`=4, assert `s_rst` for 1 cycle -> next cycle `occupancy`=0 and `dst_vaild`=0, and none of the 4 words ever appear.
